// File: rtl/serial_tx_if.sv
// Word handshake between the register bank read port and the serial transmitter.
interface serial_tx_if #(
    parameter int WIDTH = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in;

    modport master (output in_valid, output in, input in_ready);
    modport slave  (input in_valid, input in, output in_ready);
endinterface

// File: rtl/serial_tx.sv
// Parallel-to-serial transmitter: start bit 0, WIDTH data bits LSB first, stop bit 1,
// each bit held CLKS_PER_BIT clocks.
//
//   state | meaning
//   IDLE  | line at 1, ready to accept a word
//   START | start bit (0) on the line
//   DATA  | shift register LSB on the line, one bit per bit period
//   STOP  | stop bit (1) on the line; done pulses as it ends
module serial_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    serial_tx_if.slave  bus,
    output logic        tx_out,
    output logic        busy,
    output logic        done
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic [BW-1:0]    bit_cnt, bit_cnt_nxt;
    logic [CW-1:0]    cyc_cnt, cyc_cnt_nxt;
    logic             tx_nxt, busy_nxt, done_nxt;
    logic             bit_end;

    assign bus.in_ready = (state == IDLE);
    assign bit_end      = (cyc_cnt == CYC_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            cyc_cnt <= '0;
            tx_out  <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            shreg   <= shreg_nxt;
            bit_cnt <= bit_cnt_nxt;
            cyc_cnt <= cyc_cnt_nxt;
            tx_out  <= tx_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        bit_cnt_nxt = bit_cnt;
        cyc_cnt_nxt = bit_end ? '0 : cyc_cnt + 1'b1;
        done_nxt    = 1'b0;
        case (state)
            IDLE: begin
                cyc_cnt_nxt = '0;
                if (bus.in_valid) begin
                    shreg_nxt = bus.in;
                    state_nxt = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_nxt   = DATA;
                    bit_cnt_nxt = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shreg_nxt   = shreg >> 1;
                    bit_cnt_nxt = bit_cnt + 1'b1;
                    if (bit_cnt == BIT_LAST)
                        state_nxt = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Outputs are registered, so the line level is derived from the state being entered.
        case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = shreg_nxt[0];
            default: tx_nxt = 1'b1;
        endcase
        busy_nxt = (state_nxt != IDLE);
    end
endmodule

// File: tb/tb_serial_tx.sv
// Scoreboard bench for serial_tx: stimulus queues hand-written line patterns,
// a monitor reassembles each frame off the line and compares.
module tb_serial_tx;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    serial_tx_if #(.WIDTH(8)) bus0 ();
    serial_tx_if #(.WIDTH(8)) bus1 ();
    logic tx0, busy0, done0;
    logic tx1, busy1, done1;

    serial_tx #(.WIDTH(8), .CLKS_PER_BIT(4)) dut (
        .clk(clk), .rst(rst), .bus(bus0), .tx_out(tx0), .busy(busy0), .done(done0));
    serial_tx #(.WIDTH(8), .CLKS_PER_BIT(1)) dut_c (
        .clk(clk), .rst(rst), .bus(bus1), .tx_out(tx1), .busy(busy1), .done(done1));

    // pat: line levels in send order, MSB = start bit, LSB = stop bit
    typedef struct {
        logic [9:0] pat;
        bit         aborted;
        bit         chk_gap;
        int         gap;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    bit   sel = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    task automatic push_exp(input logic [9:0] pat, input bit ab, input bit cg, input int g);
        exp_t e;
        e.pat = pat; e.aborted = ab; e.chk_gap = cg; e.gap = g;
        exp_q.push_back(e);
    endtask

    task automatic drive(input bit v, input logic [7:0] w);
        if (sel) begin bus1.in_valid = v; bus1.in = w; end
        else     begin bus0.in_valid = v; bus0.in = w; end
    endtask

    function automatic logic rdy();
        return sel ? bus1.in_ready : bus0.in_ready;
    endfunction

    function automatic logic cur_busy();
        return sel ? busy1 : busy0;
    endfunction

    function automatic logic cur_done();
        return sel ? done1 : done0;
    endfunction

    // Called at a negedge with in_valid driven; returns at the negedge after acceptance.
    task automatic wait_accept(output bit done_at_acc);
        int n = 0;
        while (rdy() !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (rdy() !== 1'b1) begin
            checks++; errors++;
            $display("FAIL accept_timeout: in_ready still %0b after %0d cycles, expected 1", rdy(), n);
        end
        done_at_acc = cur_done();
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((cur_busy() !== 1'b0 || rdy() !== 1'b1) && n < 500);
        if (cur_busy() !== 1'b0) begin
            checks++; errors++;
            $display("FAIL idle_timeout: busy still %0b after %0d cycles, expected 0", cur_busy(), n);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin : monitor
        bit   in_frame = 1'b0;
        bit   expect_done = 1'b0;
        bit   idle_ok = 1'b1;
        bit   bit_ok = 1'b1;
        int   cnt = 0;
        int   gap = 0;
        int   cpb;
        int   k;
        logic t, b, d;
        exp_t cur;
        cur.pat = 10'h3FF; cur.aborted = 1'b0; cur.chk_gap = 1'b0; cur.gap = 0;
        forever begin
            @(negedge clk);
            t   = sel ? tx1 : tx0;
            b   = sel ? busy1 : busy0;
            d   = sel ? done1 : done0;
            cpb = sel ? 1 : 4;

            if (expect_done) begin
                check("done_pulse", d, 1'b1);
                expect_done = 1'b0;
            end else if (d !== 1'b0) begin
                checks++; errors++;
                $display("FAIL done_unexpected: done=%0b outside frame end, expected 0", d);
            end

            if (!in_frame) begin
                if (b === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL frame_unexpected: busy=1 with no word queued, expected idle");
                        cur.pat = 10'h3FF; cur.aborted = 1'b0; cur.chk_gap = 1'b0;
                    end else begin
                        cur = exp_q.pop_front();
                    end
                    if (cur.chk_gap) begin
                        check("gap_len", gap, cur.gap);
                        check("gap_line_idle", idle_ok, 1'b1);
                    end
                    in_frame = 1'b1;
                    cnt      = 0;
                    bit_ok   = 1'b1;
                end else begin
                    gap++;
                    if (t !== 1'b1) idle_ok = 1'b0;
                end
            end

            if (in_frame) begin
                if (b !== 1'b1) begin
                    check("abort_expected", cur.aborted, 1'b1);
                    check("abort_line_idle", t, 1'b1);
                    in_frame = 1'b0;
                    gap      = 0;
                    idle_ok  = 1'b1;
                end else begin
                    k = cnt / cpb;
                    if (t !== cur.pat[9-k]) bit_ok = 1'b0;
                    if (cnt % cpb == cpb - 1) begin
                        checks++;
                        if (!bit_ok) begin
                            errors++;
                            $display("FAIL frame_bit%0d: line not held at %0b for %0d cycles (last sample %0b)",
                                     k, cur.pat[9-k], cpb, t);
                        end
                        bit_ok = 1'b1;
                    end
                    cnt++;
                    if (cnt == 10 * cpb) begin
                        check("frame_not_aborted", cur.aborted, 1'b0);
                        in_frame    = 1'b0;
                        expect_done = 1'b1;
                        gap         = 0;
                        idle_ok     = 1'b1;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        bit da;
        bus0.in_valid = 1'b0; bus0.in = '0;
        bus1.in_valid = 1'b0; bus1.in = '0;
        rst = 1'b0;
        drive(1'b1, 8'hFF);
        repeat (3) begin
            @(negedge clk);
            check("rst_tx_out", tx0, 1'b1);
            check("rst_busy", busy0, 1'b0);
            check("rst_done", done0, 1'b0);
            check("rst_in_ready", bus0.in_ready, 1'b1);
        end
        rst = 1'b1;
        drive(1'b0, 8'h00);
        repeat (2) @(negedge clk);

        // single frame 0xA5
        push_exp(10'b0_10100101_1, 1'b0, 1'b0, 0);
        drive(1'b1, 8'hA5);
        wait_accept(da);
        drive(1'b0, 8'h00);
        wait_idle();

        // back-to-back 0x00 then 0xFF
        push_exp(10'b0_00000000_1, 1'b0, 1'b0, 0);
        push_exp(10'b0_11111111_1, 1'b0, 1'b1, 1);
        drive(1'b1, 8'h00);
        wait_accept(da);
        drive(1'b1, 8'hFF);
        wait_accept(da);
        check("b2b_accept_on_done", da, 1'b1);
        drive(1'b0, 8'h00);
        wait_idle();

        // 0xC3 offered throughout the 0x3C frame
        push_exp(10'b0_00111100_1, 1'b0, 1'b0, 0);
        push_exp(10'b0_11000011_1, 1'b0, 1'b1, 1);
        drive(1'b1, 8'h3C);
        wait_accept(da);
        drive(1'b1, 8'hC3);
        repeat (10) begin
            check("busy_in_ready_low", rdy(), 1'b0);
            @(negedge clk);
        end
        wait_accept(da);
        check("held_word_accept_on_done", da, 1'b1);
        drive(1'b0, 8'h00);
        wait_idle();

        // reset during data bit 3 of 0x55
        push_exp(10'b0_10101010_1, 1'b1, 1'b0, 0);
        drive(1'b1, 8'h55);
        wait_accept(da);
        drive(1'b0, 8'h00);
        repeat (17) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("abort_tx_out", tx0, 1'b1);
        check("abort_busy", busy0, 1'b0);
        repeat (3) begin
            @(negedge clk);
            check("abort_no_done", done0, 1'b0);
        end

        push_exp(10'b0_10000001_1, 1'b0, 1'b0, 0);
        drive(1'b1, 8'h81);
        wait_accept(da);
        drive(1'b0, 8'h00);
        wait_idle();

        // one clock per bit
        sel = 1'b1;
        @(negedge clk);
        push_exp(10'b0_10000000_1, 1'b0, 1'b0, 0);
        drive(1'b1, 8'h01);
        wait_accept(da);
        drive(1'b0, 8'h00);
        wait_idle();

        check("scoreboard_drained", exp_q.size(), 0);
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/serial_tx.md
Name: serial_tx

Overview:
- Parallel-to-serial transmitter that reads a WIDTH-bit word from a register bank output using a valid/ready handshake.
- Sends the word on a single line as a framed stream: start bit (0), data LSB first, stop bit (1).
- It is the read/transmit end of the register-bank data path. Its frame is the one the team's serial receiver expects.

Parameters:
- WIDTH, 8, number of data bits per frame (>=1).
- CLKS_PER_BIT, 4, clk cycles each serial bit is held on tx_out (>=1).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-low reset.
- in_valid  input  1  producer has a word on in.
- in_ready  output  1  transmitter can accept a word. Combinational: high iff state==IDLE.
- in  input  WIDTH  parallel data word, sampled only on acceptance.
- tx_out  output  1  serial line, registered; idle level 1.
- busy  output  1  high while a frame is in progress (state!=IDLE).
- done  output  1  one-cycle pulse after a frame's stop bit completes.

Behaviour:
- Interface: reset rst, synchronous, active-low; clock clk.
- Reset (rst==0 at a posedge) forces:
  - state=IDLE, tx_out=1, busy=0, done=0
  - shift register=0, bit counter=0, cycle counter=0
  - in_ready therefore reads 1
- Reset has priority over every other event, including a handshake in the same cycle.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - tx_out=1.
  - Acceptance occurs when in_valid&&in_ready at a posedge: shift register<=in, state<=START, cycle counter<=0.
  - Without acceptance, stay in IDLE. in is ignored outside acceptance.
- START: tx_out=0 for exactly CLKS_PER_BIT cycles, starting the cycle after acceptance. Then go to DATA with bit counter=0.
- DATA:
  - tx_out=shift register[0], held CLKS_PER_BIT cycles per bit.
  - At each bit boundary, shift right by one and increment the bit counter.
  - After WIDTH bits, go to STOP.
- STOP:
  - tx_out=1 for CLKS_PER_BIT cycles.
  - At the posedge ending the stop bit: state<=IDLE, done<=1.
- done is high for exactly the first IDLE cycle after a frame and low otherwise.
- Frame length: exactly (WIDTH+2)*CLKS_PER_BIT cycles of tx_out from the cycle after acceptance.
- Back-to-back frames:
  - A word may be accepted in the same cycle done is high.
  - The line therefore sits at 1 for a minimum of 1 idle cycle between frames.
- in_valid while busy has no effect (in_ready=0). Words are never dropped or overwritten mid-frame.
- Cycle counter:
  - Width max(1,$clog2(CLKS_PER_BIT)); counts 0..CLKS_PER_BIT-1 and wraps at each bit boundary.
  - CLKS_PER_BIT=1 gives one cycle per bit and must work.
- Bit counter: width $clog2(WIDTH+1). No wrap beyond WIDTH.
- Reset mid-frame:
  - Aborts the frame; tx_out=1 from the next cycle.
  - No done pulse; the partial word is discarded.
- tx_out, busy and done are glitch-free registered outputs. in_ready is the only combinational output.

Test Plan:
- Reset values: hold rst=0 for 3 cycles with in_valid=1 and in=0xFF. Require tx_out=1, busy=0, done=0, in_ready=1 throughout, and no frame starts.
- Single frame, defaults (WIDTH=8, CLKS_PER_BIT=4), in=0xA5 accepted at cycle T:
  - tx_out over cycles T+1..T+40 = 0×4, then bits 1,0,1,0,0,1,0,1 (4 cycles each), then 1×4.
  - busy=1 during T+1..T+40; done=1 at T+41 only.
- Back-to-back: keep in_valid=1 with 0x00 then 0xFF. Require the second acceptance on the done cycle and exactly 1 idle cycle (tx_out=1) between the frames. Data bits: all 0, then all 1.
- Busy protection: during the 0x3C frame, drive in_valid=1 and in=0xC3 for 10 cycles. Require in_ready=0, the transmitted bits to match 0x3C (0,0,1,1,1,1,0,0), and 0xC3 to be accepted only after done.
- Reset mid-frame: assert rst=0 during DATA bit 3 of 0x55. Require tx_out=1 and busy=0 from the next cycle, done never pulses, and a later 0x81 frame is correct.
- Corner parameters: CLKS_PER_BIT=1, WIDTH=8, in=0x01. Require a 10-cycle frame 0,1,0,0,0,0,0,0,0,1 and done in cycle 11.
